i2s_adc_rx: RTL and testbench

- I2S master receiver for the Pmod I2S2 ADC path (CS5343). It is the stage directly upstream of the loopback/DSP logic in toplevel.
- Generates adc_mclk, adc_sclk and adc_lrck from clk100 and deserializes adc_sdata into 24-bit left/right samples.
- Presents each completed stereo frame on a valid/ready output port, flags overruns, and keeps left and right samples frame-coherent.

---
 rtl/i2s_adc_rx.sv | 87 ++++++++
 tb/tb_i2s_adc_rx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_adc_rx.sv
// I2S master receiver for the CS5343 ADC: derives mclk/sclk/lrck from clk100 and
// delivers frame-coherent stereo samples on valid/ready. Optional macro I2S_ADC_RX_OVF_CNT_EN adds ovf_cnt.
module i2s_adc_rx #(
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk100,
  input  logic              rst,
  output logic              adc_mclk,
  output logic              adc_sclk,
  output logic              adc_lrck,
  input  logic              adc_sdata,
  output logic [DATA_W-1:0] l_data,
  output logic [DATA_W-1:0] r_data,
  output logic              valid,
  input  logic              ready,
  output logic              overrun
`ifdef I2S_ADC_RX_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_cnt
`endif
);

  localparam int unsigned CNT_W     = 11;
  localparam logic [4:0]  LAST_SLOT = 5'(DATA_W);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] l_shift;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] l_hold;
  logic [DATA_W-1:0] l_next_c;
  logic [DATA_W-1:0] r_next_c;
  logic [4:0]        slot_c;
  logic              strobe_c;
  logic              in_slot_c;
  logic              left_done_c;
  logic              frame_done_c;

  // Clock outputs are plain register bits, so they cannot glitch.
  assign adc_mclk = cnt[1];
  assign adc_sclk = cnt[4];
  assign adc_lrck = cnt[10];

  assign slot_c       = cnt[9:5];
  assign strobe_c     = (cnt[4:0] == 5'd15);
  assign in_slot_c    = (slot_c != 5'd0) && (slot_c <= LAST_SLOT);
  assign l_next_c     = DATA_W'({l_shift, adc_sdata});
  assign r_next_c     = DATA_W'({r_shift, adc_sdata});
  assign left_done_c  = strobe_c && !cnt[10] && (slot_c == LAST_SLOT);
  assign frame_done_c = strobe_c &&  cnt[10] && (slot_c == LAST_SLOT);

  always_ff @(posedge clk100) begin
    if (rst) begin
      cnt     <= '0;
      l_shift <= '0;
      r_shift <= '0;
      l_hold  <= '0;
      l_data  <= '0;
      r_data  <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
`ifdef I2S_ADC_RX_OVF_CNT_EN
      ovf_cnt <= 8'd0;
`endif
    end else begin
      cnt     <= cnt + CNT_W'(1);
      overrun <= 1'b0;

      if (strobe_c && in_slot_c && !cnt[10]) l_shift <= l_next_c;
      if (strobe_c && in_slot_c &&  cnt[10]) r_shift <= r_next_c;
      if (left_done_c) l_hold <= l_next_c;

      // A new frame always wins; an unaccepted old frame is reported as lost.
      if (frame_done_c) begin
        l_data  <= l_hold;
        r_data  <= r_next_c;
        valid   <= 1'b1;
        overrun <= valid && !ready;
`ifdef I2S_ADC_RX_OVF_CNT_EN
        if (valid && !ready && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
`endif
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Self-checking bench for i2s_adc_rx: an ADC stimulus model plus a frame/handshake
// reference model computed from cycle counts since reset.
`timescale 1ns/1ps
module tb_i2s_adc_rx;

  localparam int DW    = 24;
  localparam int FRAME = 2048;
  localparam int LAT   = 1024 + 32*DW + 16;
  localparam int NF    = 8;

  logic          clk100 = 1'b0;
  logic          rst = 1'b1;
  logic          adc_mclk, adc_sclk, adc_lrck;
  logic          adc_sdata = 1'b0;
  logic [DW-1:0] l_data, r_data;
  logic          valid;
  logic          ready = 1'b0;
  logic          overrun;
`ifdef I2S_ADC_RX_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  i2s_adc_rx #(.DATA_W(DW)) dut (
    .clk100    (clk100),
    .rst       (rst),
    .adc_mclk  (adc_mclk),
    .adc_sclk  (adc_sclk),
    .adc_lrck  (adc_lrck),
    .adc_sdata (adc_sdata),
    .l_data    (l_data),
    .r_data    (r_data),
    .valid     (valid),
    .ready     (ready),
    .overrun   (overrun)
`ifdef I2S_ADC_RX_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clk100 = ~clk100;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame words transmitted by the ADC model, indexed by frame number since reset.
  logic [DW-1:0] lw [NF];
  logic [DW-1:0] rw [NF];

  // Reference model: tc = clk100 edges since reset release.
  int            tc = 0;
  logic          m_valid = 1'b0;
  logic          m_ovr = 1'b0;
  logic [DW-1:0] m_l = '0;
  logic [DW-1:0] m_r = '0;
  int            m_ovf = 0;

  function automatic logic sdata_for(input int t);
    int ph, s, f;
    logic [DW-1:0] w;
    ph = t % FRAME;
    s  = (ph % 1024) / 32;
    f  = (t / FRAME) % NF;
    w  = (ph >= 1024) ? rw[f] : lw[f];
    if (s >= 1 && s <= DW) return w[DW - s];
    return 1'($urandom % 2);
  endfunction

  always @(posedge clk100) begin
    int f;
    if (rst) begin
      tc = 0; m_valid = 0; m_ovr = 0; m_l = '0; m_r = '0; m_ovf = 0;
    end else begin
      tc    = tc + 1;
      m_ovr = 0;
      if (tc >= LAT && ((tc - LAT) % FRAME) == 0) begin
        f       = ((tc - LAT) / FRAME) % NF;
        m_ovr   = m_valid && !ready;
        if (m_ovr && m_ovf < 255) m_ovf = m_ovf + 1;
        m_valid = 1;
        m_l     = lw[f];
        m_r     = rw[f];
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
    end
    // ADC changes data just after the sclk falling edge.
    #1 adc_sdata = sdata_for(tc);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk100);
      #2;
    end
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    step(n);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (valid !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NF; i++) begin
      lw[i] = DW'($urandom);
      rw[i] = DW'($urandom);
    end
  endtask

  task automatic test_reset();
    fill_random();
    rst = 1'b0;
    step(700);
    rst = 1'b1;
    step(2);
    n_checks++; if ({adc_mclk, adc_sclk, adc_lrck} !== 3'b000) begin n_fail++; $display("FAIL reset_clocks got %b exp 000", {adc_mclk, adc_sclk, adc_lrck}); end
    n_checks++; if (l_data !== '0) begin n_fail++; $display("FAIL reset_l got %h exp 0", l_data); end
    n_checks++; if (r_data !== '0) begin n_fail++; $display("FAIL reset_r got %h exp 0", r_data); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
`ifdef I2S_ADC_RX_OVF_CNT_EN
    n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ovf_cnt got %0d exp 0", ovf_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_clocks();
    logic   pm, ps, pl;
    longint tm [2];
    longint ts [2];
    longint tl [2];
    fill_random();
    apply_reset(2);
    pm = adc_mclk; ps = adc_sclk; pl = adc_lrck;
    tm[0] = 0; tm[1] = 0; ts[0] = 0; ts[1] = 0; tl[0] = 0; tl[1] = 0;
    for (int i = 0; i < 3200; i++) begin
      step(1);
      n_checks++;
      if (adc_mclk !== 1'((tc / 2) % 2) || adc_sclk !== 1'((tc / 16) % 2) || adc_lrck !== 1'((tc / 1024) % 2)) begin
        n_fail++;
        $display("FAIL clk_levels tc=%0d got mclk=%b sclk=%b lrck=%b", tc, adc_mclk, adc_sclk, adc_lrck);
      end
      if (adc_lrck !== pl) begin
        n_checks++;
        if (!(ps === 1'b1 && adc_sclk === 1'b0)) begin
          n_fail++;
          $display("FAIL lrck_edge tc=%0d sclk %b->%b exp falling", tc, ps, adc_sclk);
        end
      end
      if (adc_mclk && !pm) begin tm[0] = tm[1]; tm[1] = $time; end
      if (adc_sclk && !ps) begin ts[0] = ts[1]; ts[1] = $time; end
      if (adc_lrck && !pl) begin tl[0] = tl[1]; tl[1] = $time; end
      pm = adc_mclk; ps = adc_sclk; pl = adc_lrck;
    end
    n_checks++; if (tm[1] - tm[0] != 40) begin n_fail++; $display("FAIL mclk_period got %0d exp 40", tm[1] - tm[0]); end
    n_checks++; if (ts[1] - ts[0] != 320) begin n_fail++; $display("FAIL sclk_period got %0d exp 320", ts[1] - ts[0]); end
    n_checks++; if (tl[1] - tl[0] != 20480) begin n_fail++; $display("FAIL lrck_period got %0d exp 20480", tl[1] - tl[0]); end
  endtask

  task automatic test_single();
    int n;
    fill_random();
    lw[0] = 24'h555555; rw[0] = 24'h123456;
    ready = 1'b1;
    apply_reset(2);
    wait_valid(4000, n);
    n_checks++; if (n != LAT) begin n_fail++; $display("FAIL single_latency got %0d exp %0d", n, LAT); end
    n_checks++; if (l_data !== 24'h555555) begin n_fail++; $display("FAIL single_l got %h exp 555555", l_data); end
    n_checks++; if (r_data !== 24'h123456) begin n_fail++; $display("FAIL single_r got %h exp 123456", r_data); end
    step(1);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_pulse got %b exp 0", valid); end
    ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    fill_random();
    lw[0] = 24'h800001; rw[0] = 24'h7FFFFF;
    ready = 1'b0;
    apply_reset(2);
    wait_valid(4000, n);
    n_checks++; if (n != LAT) begin n_fail++; $display("FAIL bp_latency got %0d exp %0d", n, LAT); end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      n_checks++;
      if (valid !== 1'b1 || l_data !== 24'h800001 || r_data !== 24'h7FFFFF || overrun !== 1'b0) begin
        n_fail++;
        if (bad < 5) $display("FAIL bp_hold cyc=%0d got v=%b l=%h r=%h ov=%b exp v=1 l=800001 r=7fffff ov=0", i, valid, l_data, r_data, overrun);
        bad++;
      end
    end
    ready = 1'b1;
    step(1);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %b exp 0", valid); end
    ready = 1'b0;
  endtask

  task automatic test_overrun();
    int pulses;
    int at;
    fill_random();
    lw[0] = 24'h800001; rw[0] = 24'h7FFFFF;
    lw[1] = 24'h0F0F0F; rw[1] = 24'hF0F0F0;
    ready = 1'b0;
    apply_reset(2);
    pulses = 0; at = -1;
    while (tc < LAT + FRAME + 4) begin
      step(1);
      if (overrun === 1'b1) begin pulses++; at = tc; end
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL ovr_pulses got %0d exp 1", pulses); end
    n_checks++; if (at != LAT + FRAME) begin n_fail++; $display("FAIL ovr_time got %0d exp %0d", at, LAT + FRAME); end
    n_checks++; if (l_data !== 24'h0F0F0F || r_data !== 24'hF0F0F0 || valid !== 1'b1) begin
      n_fail++; $display("FAIL ovr_data got v=%b l=%h r=%h exp v=1 l=0f0f0f r=f0f0f0", valid, l_data, r_data);
    end
`ifdef I2S_ADC_RX_OVF_CNT_EN
    n_checks++; if (ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_cnt got %0d exp 1", ovf_cnt); end
`endif
  endtask

  task automatic test_same_cycle();
    int n;
    fill_random();
    ready = 1'b0;
    apply_reset(2);
    wait_valid(4000, n);
    n_checks++; if (n != LAT) begin n_fail++; $display("FAIL same_latency got %0d exp %0d", n, LAT); end
    while (tc < LAT + FRAME - 1) begin
      step(1);
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL same_hold tc=%0d got %b exp 1", tc, valid); end
    end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL same_valid got %b exp 1", valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL same_overrun got %b exp 0", overrun); end
    n_checks++; if (l_data !== lw[1] || r_data !== rw[1]) begin
      n_fail++; $display("FAIL same_data got l=%h r=%h exp l=%h r=%h", l_data, r_data, lw[1], rw[1]);
    end
    step(3);
    n_checks++; if (valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL same_after got v=%b ov=%b exp v=1 ov=0", valid, overrun); end
  endtask

  task automatic test_reset_mid();
    int n;
    fill_random();
    ready = 1'b1;
    apply_reset(2);
    while (tc < FRAME + 1500) step(1);
    rst = 1'b1;
    step(3);
    n_checks++; if ({adc_mclk, adc_sclk, adc_lrck, valid, overrun} !== 5'b0 || l_data !== '0 || r_data !== '0) begin
      n_fail++; $display("FAIL mid_reset got clk=%b%b%b v=%b ov=%b l=%h r=%h exp all 0", adc_mclk, adc_sclk, adc_lrck, valid, overrun, l_data, r_data);
    end
    lw[0] = DW'($urandom); rw[0] = DW'($urandom);
    rst = 1'b0;
    wait_valid(4000, n);
    n_checks++; if (n != LAT) begin n_fail++; $display("FAIL mid_latency got %0d exp %0d", n, LAT); end
    n_checks++; if (l_data !== lw[0] || r_data !== rw[0]) begin
      n_fail++; $display("FAIL mid_data got l=%h r=%h exp l=%h r=%h", l_data, r_data, lw[0], rw[0]);
    end
  endtask

  task automatic test_random();
    int bad;
    fill_random();
    ready = 1'b0;
    apply_reset(2);
    bad = 0;
    for (int i = 0; i < 6 * FRAME; i++) begin
      ready = ((tc / FRAME) % 3 != 1) && ($urandom % 4 == 0);
      step(1);
      n_checks++;
      if (valid !== m_valid || l_data !== m_l || r_data !== m_r || overrun !== m_ovr) begin
        n_fail++;
        if (bad < 5) $display("FAIL rand tc=%0d got v=%b l=%h r=%h ov=%b exp v=%b l=%h r=%h ov=%b",
                              tc, valid, l_data, r_data, overrun, m_valid, m_l, m_r, m_ovr);
        bad++;
      end
`ifdef I2S_ADC_RX_OVF_CNT_EN
      n_checks++; if (ovf_cnt !== 8'(m_ovf)) begin n_fail++; if (bad < 5) $display("FAIL rand_ovf got %0d exp %0d", ovf_cnt, m_ovf); bad++; end
`endif
    end
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clocks();
    test_single();
    test_backpressure();
    test_overrun();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
